// File: rtl/jk_seq_ctrl_pkg.sv
// Shared types for the jk_seq_ctrl excitation controller: FSM encoding and the
// JK excitation rules used to steer each flop toward its target value.
package jk_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Don't-care entries resolve to 0, so J=K=1 (toggle) is never requested.
  function automatic logic excite_j(input logic q, input logic nxt);
    return ~q & nxt;
  endfunction

  function automatic logic excite_k(input logic q, input logic nxt);
    return q & ~nxt;
  endfunction

endpackage

// File: rtl/jk_seq_ctrl_excite.sv
// One-bit JK excitation: present Q and target bit in, J/K drive out.
module jk_seq_ctrl_excite
  import jk_seq_ctrl_pkg::*;
(
  input  logic q,
  input  logic nxt,
  output logic j,
  output logic k
);

  assign j = excite_j(q, nxt);
  assign k = excite_k(q, nxt);

endmodule

// File: rtl/jk_seq_ctrl.sv
// Excitation controller turning an external bank of W JK flops into a
// modulo-MOD up/down counter with a one-cycle parallel-load handshake.
module jk_seq_ctrl
  import jk_seq_ctrl_pkg::*;
#(
  parameter int W   = 4,
  parameter int MOD = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  input  logic         ld_valid,
  input  logic [W-1:0] ld_data,
  output logic         ld_ready,
  output logic         ld_err,
  input  logic [W-1:0] q_in,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic         tc,
  output logic         busy
);

  // The modulus may equal 2**W, so range tests against it need one extra bit.
  localparam logic [W:0]   MOD_X = (W + 1)'(MOD);
  localparam logic [W-1:0] MAX_V = W'(MOD - 1);

  state_t       state, state_nxt;
  logic [W-1:0] ld_reg;
  logic [W-1:0] nxt;
  logic         accept;
  logic         q_hi, q_over, ld_over;

  assign q_hi    = (q_in >= MAX_V);
  assign q_over  = ({1'b0, q_in} >= MOD_X);
  assign ld_over = ({1'b0, ld_data} >= MOD_X);

  assign busy     = (state == ST_LOAD);
  assign ld_ready = clr & ((state == ST_IDLE) | (state == ST_RUN));
  assign accept   = ld_valid & ld_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, independent of block order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (accept)  state_nxt = ST_LOAD;
        else if (en) state_nxt = ST_RUN;
        else         state_nxt = ST_IDLE;
      end
      ST_LOAD: state_nxt = en ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Target value the bank should hold after the next edge.
  always_comb begin
    nxt = q_in;
    case (state)
      ST_RUN: begin
        if (up) nxt = q_hi ? '0 : q_in + W'(1);
        else    nxt = ((q_in == '0) || q_over) ? MAX_V : q_in - W'(1);
      end
      ST_LOAD: nxt = ld_reg;
      default: nxt = q_in;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ld_reg <= '0;
      ld_err <= 1'b0;
      tc     <= 1'b0;
    end else begin
      ld_err <= accept & ld_over;
      tc     <= (state == ST_RUN) & (up ? (q_in == MAX_V) : (q_in == '0));
      if (accept) ld_reg <= ld_over ? MAX_V : ld_data;
    end
  end

  for (genvar i = 0; i < W; i++) begin : g_bit
    jk_seq_ctrl_excite u_excite (
      .q   (q_in[i]),
      .nxt (nxt[i]),
      .j   (j[i]),
      .k   (k[i])
    );
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl driving a behavioural bank of four JK flops (BCD digit);
// expectations come from an arithmetic counter model via a scoreboard queue.
module tb_jk_seq_ctrl;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         clr;
  logic         en, up, ld_valid;
  logic [W-1:0] ld_data;
  logic         ld_ready, ld_err, tc, busy;
  logic [W-1:0] q, j, k;
  logic         preset;
  logic [W-1:0] preset_val;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int q;
    bit tc;
    bit err;
    bit busy;
    bit ready;
  } exp_t;

  exp_t sb[$];

  // Counter model: value, whether counting was enabled, pending load.
  int m_q;
  bit m_active;
  bit m_busy;
  int m_pend;

  always #5 clk = ~clk;

  // Bank of JK flops sharing clk/clr; preset lets the bench force any value.
  always @(posedge clk or negedge clr) begin
    if (!clr) q <= '0;
    else if (preset) q <= preset_val;
    else begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b10:   q[i] <= 1'b1;
          2'b01:   q[i] <= 1'b0;
          2'b11:   q[i] <= ~q[i];
          default: q[i] <= q[i];
        endcase
      end
    end
  end

  jk_seq_ctrl #(.W(W), .MOD(MOD)) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .up       (up),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_err   (ld_err),
    .q_in     (q),
    .j        (j),
    .k        (k),
    .tc       (tc),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q      = 0;
    m_active = 0;
    m_busy   = 0;
    m_pend   = 0;
  endtask

  // Drive one cycle of inputs, predict the state after the next edge, queue it.
  task automatic step(input bit e, input bit u, input bit v, input int d);
    exp_t x;
    bit   acc;
    int   nq;
    en       = e;
    up       = u;
    ld_valid = v;
    ld_data  = d[W-1:0];
    acc = v && !m_busy;
    if (preset)        nq = int'(preset_val);
    else if (m_busy)   nq = m_pend;
    else if (m_active) begin
      if (u) nq = (m_q >= MOD - 1) ? 0 : m_q + 1;
      else   nq = (m_q == 0 || m_q >= MOD) ? MOD - 1 : m_q - 1;
    end else nq = m_q;
    x.q     = nq;
    x.tc    = m_active && !m_busy && (u ? (m_q == MOD - 1) : (m_q == 0));
    x.err   = acc && (d >= MOD);
    x.busy  = acc;
    x.ready = !acc;
    if (acc) m_pend = (d >= MOD) ? MOD - 1 : d;
    m_busy   = acc;
    m_active = e;
    m_q      = nq;
    sb.push_back(x);
    @(negedge clk);
    #1;
  endtask

  // Monitor: one expectation per edge, compared on the following falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q",        q,        e.q);
        check("tc",       tc,       e.tc);
        check("ld_err",   ld_err,   e.err);
        check("busy",     busy,     e.busy);
        check("ld_ready", ld_ready, e.ready);
        check("jk_both",  j & k,    0);
      end
    end
  end

  initial begin
    clr        = 1'b0;
    en         = 1'b0;
    up         = 1'b1;
    ld_valid   = 1'b0;
    ld_data    = '0;
    preset     = 1'b0;
    preset_val = '0;
    model_reset();

    // Reset held for two cycles.
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    check("rst_q",        q,        0);
    check("rst_j",        j,        0);
    check("rst_k",        k,        0);
    check("rst_tc",       tc,       0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_busy",     busy,     0);
    clr = 1'b1;
    #1;
    check("rel_ld_ready", ld_ready, 1);

    // Count up from 0 through the wrap.
    step(1, 1, 0, 0);
    repeat (12) step(1, 1, 0, 0);
    check("up_end_q", q, 2);

    // Count down from 2 through the wrap.
    repeat (4) step(1, 0, 0, 0);
    check("down_end_q", q, 8);

    // Load 7 while running at 3: the accept cycle still counts.
    repeat (5) step(1, 1, 0, 0);
    check("pre_load_q", q, 3);
    step(1, 1, 1, 7);
    check("load_cnt_q", q, 4);
    step(1, 1, 0, 0);
    check("load_q", q, 7);

    // Out-of-range load clamps; a request during LOAD is ignored.
    step(1, 1, 1, 12);
    step(1, 1, 1, 5);
    check("clamp_q", q, 9);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);

    // Preset an illegal value while idle, then recover on the first counting edge.
    step(0, 1, 0, 0);
    preset     = 1'b1;
    preset_val = 4'd13;
    step(0, 1, 0, 0);
    preset = 1'b0;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("recover_q", q, 0);

    // Reset asserted mid-LOAD aborts the load.
    step(1, 1, 0, 0);
    step(1, 1, 1, 6);
    clr = 1'b0;
    #1;
    check("abort_busy",     busy,     0);
    check("abort_ld_ready", ld_ready, 0);
    check("abort_q",        q,        0);
    @(negedge clk);
    #1;
    clr = 1'b1;
    model_reset();
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);

    // Randomized traffic, occasional illegal presets.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        preset     = 1'b1;
        preset_val = W'($urandom_range(0, 15));
      end
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 15)));
      preset = 1'b0;
    end

    @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
